// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes and an optional load-use interlock.
// Define LOAD_USE_INTERLOCK_EN to enable the hazard detector, stall output and RUN/BUBBLE FSM.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ID_valid,
  input  logic             ID_is_load,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic [2:0]       ID_FwdRisk,
  input  logic [15:0]      ID_ctrl,
  input  logic [WIDTH-1:0] ID_rd1,
  input  logic [WIDTH-1:0] ID_rd2,
  input  logic [WIDTH-1:0] ID_imm,
  input  logic [1:0]       FwdA,
  input  logic [1:0]       FwdB,
  input  logic [WIDTH-1:0] EX_result,
  input  logic [WIDTH-1:0] MEM_result,
  input  logic [WIDTH-1:0] WB_result,
  input  logic             hold,
  input  logic             flush,
  output logic             stall,
  output logic             EX_valid,
  output logic             EX_is_load,
  output logic [4:0]       EX_rd,
  output logic [2:0]       EX_FwdRisk,
  output logic [15:0]      EX_ctrl,
  output logic [WIDTH-1:0] EX_opA,
  output logic [WIDTH-1:0] EX_opB,
  output logic [WIDTH-1:0] EX_imm
);

  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic             w_stall;
  logic             w_bubble;
  logic             w_load_en;

  always_comb begin
    w_opa = ID_rd1;
    unique case (FwdA)
      2'd0: w_opa = ID_rd1;
      2'd1: w_opa = EX_result;
      2'd2: w_opa = MEM_result;
      2'd3: w_opa = WB_result;
      default: w_opa = ID_rd1;
    endcase
  end

  always_comb begin
    w_opb = ID_rd2;
    unique case (FwdB)
      2'd0: w_opb = ID_rd2;
      2'd1: w_opb = EX_result;
      2'd2: w_opb = MEM_result;
      2'd3: w_opb = WB_result;
      default: w_opb = ID_rd2;
    endcase
  end

`ifdef LOAD_USE_INTERLOCK_EN
  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_BUBBLE = 1'b1;

  logic r_state;
  logic w_state_d;
  logic w_hazard;

  assign w_hazard = EX_valid & EX_is_load & ID_valid & (EX_rd != 5'd0) &
                    ((ID_FwdRisk[0] & (ID_rs1 == EX_rd)) | (ID_FwdRisk[1] & (ID_rs2 == EX_rd)));

  // Flush wins over everything; hold still reports the hazard so the PC stays put.
  assign w_stall = (r_state == ST_RUN) & w_hazard & ~flush;

  always_comb begin
    w_state_d = ST_RUN;
    if (flush) begin
      w_state_d = ST_RUN;
    end else if (hold) begin
      w_state_d = r_state;
    end else if (w_stall) begin
      w_state_d = ST_BUBBLE;
    end else begin
      w_state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_d;
    end
  end
`else
  logic [9:0] w_unused_rs;

  assign w_unused_rs = {ID_rs1, ID_rs2};
  assign w_stall     = 1'b0;
`endif

  assign stall     = w_stall;
  assign w_load_en = flush | ~hold;
  assign w_bubble  = flush | w_stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      EX_valid   <= 1'b0;
      EX_is_load <= 1'b0;
      EX_rd      <= '0;
      EX_FwdRisk <= '0;
      EX_ctrl    <= '0;
      EX_opA     <= '0;
      EX_opB     <= '0;
      EX_imm     <= '0;
    end else if (w_load_en) begin
      if (w_bubble) begin
        EX_valid   <= 1'b0;
        EX_is_load <= 1'b0;
        EX_rd      <= '0;
        EX_FwdRisk <= '0;
        EX_ctrl    <= '0;
        EX_opA     <= '0;
        EX_opB     <= '0;
        EX_imm     <= '0;
      end else begin
        EX_valid   <= ID_valid;
        EX_is_load <= ID_is_load;
        EX_rd      <= ID_rd;
        EX_FwdRisk <= ID_FwdRisk;
        EX_ctrl    <= ID_ctrl;
        EX_opA     <= w_opa;
        EX_opB     <= w_opb;
        EX_imm     <= ID_imm;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the EX register bundle.
module tb_id_ex_stage;
  localparam int unsigned W = 32;
`ifdef LOAD_USE_INTERLOCK_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic ID_valid, ID_is_load, hold, flush, stall;
  logic [4:0] ID_rs1, ID_rs2, ID_rd;
  logic [2:0] ID_FwdRisk;
  logic [15:0] ID_ctrl;
  logic [W-1:0] ID_rd1, ID_rd2, ID_imm, EX_result, MEM_result, WB_result;
  logic [1:0] FwdA, FwdB;
  logic EX_valid, EX_is_load;
  logic [4:0] EX_rd;
  logic [2:0] EX_FwdRisk;
  logic [15:0] EX_ctrl;
  logic [W-1:0] EX_opA, EX_opB, EX_imm;

  typedef struct packed {
    logic         v;
    logic         ld;
    logic [4:0]   rd;
    logic [2:0]   risk;
    logic [15:0]  ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] imm;
  } ex_t;

  ex_t exp_q;
  ex_t obs;
  int checks = 0;
  int errors = 0;

  assign obs = {EX_valid, EX_is_load, EX_rd, EX_FwdRisk, EX_ctrl, EX_opA, EX_opB, EX_imm};

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn),
    .ID_valid(ID_valid), .ID_is_load(ID_is_load), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rd(ID_rd), .ID_FwdRisk(ID_FwdRisk), .ID_ctrl(ID_ctrl),
    .ID_rd1(ID_rd1), .ID_rd2(ID_rd2), .ID_imm(ID_imm),
    .FwdA(FwdA), .FwdB(FwdB),
    .EX_result(EX_result), .MEM_result(MEM_result), .WB_result(WB_result),
    .hold(hold), .flush(flush), .stall(stall),
    .EX_valid(EX_valid), .EX_is_load(EX_is_load), .EX_rd(EX_rd), .EX_FwdRisk(EX_FwdRisk),
    .EX_ctrl(EX_ctrl), .EX_opA(EX_opA), .EX_opB(EX_opB), .EX_imm(EX_imm)
  );

  // Reference: a load in EX whose destination a risky ID source reads must be separated
  // by one empty slot; flush kills, hold freezes.
  function automatic logic model_stall();
    logic uses;
    uses = (ID_FwdRisk[0] && ID_rs1 == exp_q.rd) || (ID_FwdRisk[1] && ID_rs2 == exp_q.rd);
    return IL && rstn && exp_q.v && exp_q.ld && ID_valid && exp_q.rd != 0 && uses && !flush;
  endfunction

  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] rf);
    logic [W-1:0] srcs [4];
    srcs[0] = rf; srcs[1] = EX_result; srcs[2] = MEM_result; srcs[3] = WB_result;
    return srcs[sel];
  endfunction

  task automatic advance();
    logic s;
    s = model_stall();
    if (!rstn || flush || (!hold && s)) exp_q = '0;
    else if (!hold)
      exp_q = {ID_valid, ID_is_load, ID_rd, ID_FwdRisk, ID_ctrl,
               pick(FwdA, ID_rd1), pick(FwdB, ID_rd2), ID_imm};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_valid = 0; ID_is_load = 0; ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0; ID_FwdRisk = 0;
    ID_ctrl = 0; ID_rd1 = 0; ID_rd2 = 0; ID_imm = 0; FwdA = 0; FwdB = 0;
    EX_result = 0; MEM_result = 0; WB_result = 0; hold = 0; flush = 0;
  endtask

  task automatic set_instr(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] risk);
    ID_valid = 1; ID_is_load = ld; ID_rd = rd; ID_rs1 = rs1; ID_rs2 = rs2; ID_FwdRisk = risk;
    ID_ctrl = 16'($urandom); ID_rd1 = $urandom; ID_rd2 = $urandom; ID_imm = $urandom;
    EX_result = $urandom; MEM_result = $urandom; WB_result = $urandom;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    set_instr(1, 5'd7, 5'd1, 5'd2, 3'b011);
    exp_q = '0;
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_bundle got %h want 0", obs); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    @(negedge clk);
    rstn = 1;
    idle_inputs();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    set_instr(0, 5'd3, 5'd1, 5'd2, 3'b000);
    FwdA = 0; ID_rd1 = 32'h11;
    advance();
    checks++;
    if (EX_valid !== 1'b1 || EX_opA !== 32'h11) begin
      errors++; $display("FAIL fwd_rf got v=%b a=%h want v=1 a=11", EX_valid, EX_opA);
    end
    @(negedge clk);
    set_instr(0, 5'd4, 5'd1, 5'd2, 3'b000);
    FwdA = 2; MEM_result = 32'hDEADBEEF; FwdB = 3; WB_result = 32'h5;
    advance();
    checks++;
    if (EX_opA !== 32'hDEADBEEF || EX_opB !== 32'h5) begin
      errors++; $display("FAIL fwd_mem_wb got a=%h b=%h want deadbeef 5", EX_opA, EX_opB);
    end
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      set_instr(0, 5'd9, 5'd1, 5'd2, 3'b000);
      FwdA = 2'(s); FwdB = 2'(3 - s);
      advance();
      checks++;
      if (obs !== exp_q) begin errors++; $display("FAIL fwd_sel%0d got %h want %h", s, obs, exp_q); end
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_instr(1, 5'd5, 5'd2, 5'd3, 3'b000);     // lw x5
    advance();
    @(negedge clk);
    set_instr(0, 5'd6, 5'd5, 5'd1, 3'b001);     // add x6,x5,x1
    FwdA = 0;
    #1;
    checks++;
    if (stall !== IL) begin errors++; $display("FAIL lu_stall got %b want %b", stall, IL); end
    advance();
    checks++;
    if (EX_valid !== !IL || obs !== exp_q) begin
      errors++; $display("FAIL lu_bubble got %h want %h", obs, exp_q);
    end
    @(negedge clk);
    FwdA = 2;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_second_stall got %b want 0", stall); end
    advance();
    checks++;
    if (EX_valid !== 1'b1 || EX_rd !== 5'd6 || EX_opA !== MEM_result) begin
      errors++; $display("FAIL lu_capture got v=%b rd=%0d a=%h want 1 6 %h",
                         EX_valid, EX_rd, EX_opA, MEM_result);
    end
    // Load to x0 never interlocks.
    @(negedge clk);
    set_instr(1, 5'd0, 5'd2, 5'd3, 3'b000);
    advance();
    @(negedge clk);
    set_instr(0, 5'd6, 5'd0, 5'd0, 3'b011);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_x0_stall got %b want 0", stall); end
    advance();
    checks++;
    if (EX_valid !== 1'b1 || obs !== exp_q) begin
      errors++; $display("FAIL lu_x0_capture got %h want %h", obs, exp_q);
    end
  endtask

  task automatic test_flush_hold();
    ex_t frozen;
    @(negedge clk);
    set_instr(1, 5'd5, 5'd2, 5'd3, 3'b000);
    advance();
    @(negedge clk);
    set_instr(0, 5'd6, 5'd1, 5'd5, 3'b010);
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
    advance();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL flush_bubble got %h want 0", obs); end
    @(negedge clk);
    flush = 0;
    set_instr(0, 5'd8, 5'd1, 5'd2, 3'b000);
    advance();
    frozen = exp_q;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_instr(1, 5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom), 3'($urandom));
      hold = 1;
      advance();
      checks++;
      if (obs !== frozen) begin errors++; $display("FAIL hold%0d got %h want %h", i, obs, frozen); end
    end
    @(negedge clk);
    hold = 0;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_instr(1, 5'd5, 5'd2, 5'd3, 3'b000);
    advance();
    @(negedge clk);
    set_instr(0, 5'd6, 5'd5, 5'd1, 3'b001);
    advance();                                  // bubble inserted when interlocked
    @(negedge clk);
    #2;
    rstn = 0;
    #1;
    checks++;
    if (EX_valid !== 1'b0 || stall !== 1'b0 || obs !== '0) begin
      errors++; $display("FAIL rst_async got v=%b s=%b bundle=%h want 0", EX_valid, stall, obs);
    end
    exp_q = '0;
    advance();
    @(negedge clk);
    rstn = 1;
    ID_valid = 0;
    advance();
    checks++;
    if (EX_valid !== 1'b0) begin errors++; $display("FAIL rst_release got v=%b want 0", EX_valid); end
    @(negedge clk);
    set_instr(0, 5'd6, 5'd5, 5'd1, 3'b001);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_resume_stall got %b want 0", stall); end
    advance();
    checks++;
    if (EX_valid !== 1'b1 || obs !== exp_q) begin
      errors++; $display("FAIL rst_resume got %h want %h", obs, exp_q);
    end
  endtask

  task automatic test_random();
    int stalls_seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      set_instr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom));
      ID_valid = ($urandom_range(0, 9) != 0);
      FwdA = 2'($urandom); FwdB = 2'($urandom);
      hold = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (stall !== model_stall()) begin
        errors++; $display("FAIL rand_stall@%0d got %b want %b", i, stall, model_stall());
      end
      if (stall) stalls_seen++;
      advance();
      checks++;
      if (obs !== exp_q) begin errors++; $display("FAIL rand_bundle@%0d got %h want %h", i, obs, exp_q); end
    end
    if (IL) begin
      checks++;
      if (stalls_seen == 0) begin errors++; $display("FAIL rand_coverage got 0 stalls want >0"); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
